// File: rtl/bcd_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_ctrl
//   Stopwatch controller for a chain of cascaded decimal (0-9) digits.
//   Divides clk into count ticks, runs the IDLE/RUN/PAUSE state machine and
//   generates the ripple carry between digits. All outputs are registered.
//
//   Optional feature macro: BCD_LAP_HOLD_EN
//     defined   : lap freezes the displayed value while counting continues;
//                 the next lap shows the live count again.
//     undefined : lap is accepted but has no effect.
//
// Parameters
//   DIGITS    number of cascaded BCD digits (1..8)
//   TICK_DIV  clk cycles per count increment (>=1)
//
// Ports
//   clk         in   system clock, all logic on posedge
//   rst         in   asynchronous active-high reset
//   start_stop  in   request, acted on at its rising edge (IDLE->RUN<->PAUSE)
//   clear       in   request, acted on at its rising edge (back to IDLE, zero)
//   lap         in   request, acted on at its rising edge (lap hold, optional)
//   bcd         out  displayed count, digit k = bcd[4k+3:4k], digit 0 = LSD
//   running     out  1 while the state machine is in RUN
//   overflow    out  sticky, set when the count wraps from all-9s to all-0s
// ---------------------------------------------------------------------------
module bcd_stopwatch_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  running,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   digits_q, digits_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            running_q, running_d;
    logic            overflow_q, overflow_d;
    logic            ss_hist_q, clr_hist_q;
    logic            ss_fire_s, clr_fire_s, tick_s, carry_s;
    logic [3:0]      digit_s;

    // Next-state logic: request edges, prescaler, digit cascade and FSM
    always_comb begin
        ss_fire_s  = start_stop & ~ss_hist_q;
        clr_fire_s = clear & ~clr_hist_q;
        tick_s     = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
        state_d    = state_q;
        digits_d   = digits_q;
        presc_d    = presc_q;
        overflow_d = overflow_q;
        carry_s    = tick_s;
        digit_s    = 4'd0;

        // Prescaler only advances in RUN, so a PAUSE resumes mid-period
        if (state_q == ST_RUN) begin
            if (tick_s) begin
                presc_d = {PW{1'b0}};
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end

        // Ripple carry: a digit steps when every digit below it is 9.
        // An out-of-range digit is forced back to 0 but does not carry.
        for (int k = 0; k < DIGITS; k++) begin
            digit_s = digits_q[4*k +: 4];
            if (carry_s) begin
                if (digit_s >= 4'd9) begin
                    digits_d[4*k +: 4] = 4'd0;
                end else begin
                    digits_d[4*k +: 4] = digit_s + 4'd1;
                end
            end else begin
                digits_d[4*k +: 4] = digit_s;
            end
            carry_s = carry_s & (digit_s == 4'd9);
        end

        // Carry out of the top digit means all-9s wrapped to all-0s
        if (carry_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        // Clear dominates start_stop; a tick in the same cycle as a
        // start_stop still lands because the cascade above is unconditional
        if (clr_fire_s) begin
            state_d    = ST_IDLE;
            digits_d   = {BW{1'b0}};
            presc_d    = {PW{1'b0}};
            overflow_d = 1'b0;
        end else if (ss_fire_s) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        running_d = (state_d == ST_RUN);
    end

`ifdef BCD_LAP_HOLD_EN
    logic            lap_hist_q, lap_fire_s;
    logic            hold_q, hold_d;
    logic [BW-1:0]   lap_val_q, lap_val_d;

    // Lap hold control and display source selection
    always_comb begin
        lap_fire_s = lap & ~lap_hist_q;
        hold_d     = hold_q;
        lap_val_d  = lap_val_q;
        if (state_d == ST_IDLE) begin
            hold_d = 1'b0;
        end else if (lap_fire_s && (state_q == ST_RUN)) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else begin
                hold_d    = 1'b1;
                lap_val_d = digits_q;
            end
        end else begin
            hold_d = hold_q;
        end
        if (hold_d) begin
            bcd_d = lap_val_d;
        end else begin
            bcd_d = digits_d;
        end
    end

    // Lap request history, hold flag and captured value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_hist_q <= 1'b0;
            hold_q     <= 1'b0;
            lap_val_q  <= {BW{1'b0}};
        end else begin
            lap_hist_q <= lap;
            hold_q     <= hold_d;
            lap_val_q  <= lap_val_d;
        end
    end
`else
    logic lap_unused_s;
    assign lap_unused_s = lap;

    // Display always follows the live count
    always_comb begin
        bcd_d = digits_d;
    end
`endif

    // Controller state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            digits_q   <= {BW{1'b0}};
            presc_q    <= {PW{1'b0}};
            ss_hist_q  <= 1'b0;
            clr_hist_q <= 1'b0;
            bcd_q      <= {BW{1'b0}};
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            presc_q    <= presc_d;
            ss_hist_q  <= start_stop;
            clr_hist_q <= clear;
            bcd_q      <= bcd_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
        end
    end

    assign bcd      = bcd_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_stopwatch_ctrl
//   Self-checking bench for bcd_stopwatch_ctrl (DIGITS=4, TICK_DIV=2).
//   Expected {running, overflow, bcd} words are queued as stimulus is driven
//   and popped when the DUT output is sampled on the falling clock edge.
//   The expected count is derived from the number of clock edges spent in
//   RUN since the last clear: count = run_edges / TICK_DIV, modulo 10000.
// ---------------------------------------------------------------------------
module tb_bcd_stopwatch_ctrl;

    logic        clk;
    logic        rst;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [15:0] bcd;
    logic        running;
    logic        overflow;

    int          n_pass = 0;
    int          n_total = 0;
    int          run_edges = 0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_v;

    bcd_stopwatch_ctrl #(
        .DIGITS   (4),
        .TICK_DIV (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .bcd        (bcd),
        .running    (running),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        int r;
        r = v % 10000;
        to_bcd = {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({running, overflow, bcd} !== 18'h0) $display("FAIL reset_state: got %h expected %h", {running, overflow, bcd}, 18'h0);
        else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({running, overflow, bcd} !== 18'h0) $display("FAIL reset_idle: got %h expected %h", {running, overflow, bcd}, 18'h0);
        else n_pass++;
    endtask

    task automatic test_count();
        logic bad;
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        run_edges = 0;
        n_total++;
        if ({running, overflow, bcd} !== {2'b10, 16'h0000}) $display("FAIL start_latency: got %h expected %h", {running, overflow, bcd}, {2'b10, 16'h0000});
        else n_pass++;
        for (int c = 0; c < 40; c++) begin
            run_edges++;
            exp_q.push_back({2'b10, to_bcd(run_edges / 2)});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_total++;
            if ({running, overflow, bcd} !== exp_v) $display("FAIL count: got %h expected %h", {running, overflow, bcd}, exp_v);
            else n_pass++;
            bad = 1'b0;
            for (int k = 0; k < 4; k++) if (bcd[4*k +: 4] > 4'd9) bad = 1'b1;
            n_total++;
            if (bad !== 1'b0) $display("FAIL nibble_range: got %h expected all nibbles <= 9", bcd);
            else n_pass++;
        end
        n_total++;
        if (bcd !== 16'h0020) $display("FAIL carry_19_20: got %h expected %h", bcd, 16'h0020);
        else n_pass++;
    endtask

    task automatic test_pause();
        // prescaler is 0 here; this RUN edge moves it to 1 and enters PAUSE
        start_stop = 1'b1;
        run_edges++;
        exp_q.push_back({2'b00, to_bcd(run_edges / 2)});
        @(negedge clk);
        start_stop = 1'b0;
        exp_v = exp_q.pop_front();
        n_total++;
        if ({running, overflow, bcd} !== exp_v) $display("FAIL pause_enter: got %h expected %h", {running, overflow, bcd}, exp_v);
        else n_pass++;
        for (int c = 0; c < 50; c++) begin
            exp_q.push_back({2'b00, 16'h0020});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_total++;
            if ({running, overflow, bcd} !== exp_v) $display("FAIL pause_frozen: got %h expected %h", {running, overflow, bcd}, exp_v);
            else n_pass++;
        end
        start_stop = 1'b1;
        exp_q.push_back({2'b10, 16'h0020});
        @(negedge clk);
        start_stop = 1'b0;
        exp_v = exp_q.pop_front();
        n_total++;
        if ({running, overflow, bcd} !== exp_v) $display("FAIL resume: got %h expected %h", {running, overflow, bcd}, exp_v);
        else n_pass++;
        run_edges++;
        exp_q.push_back({2'b10, 16'h0021});
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_total++;
        if ({running, overflow, bcd} !== exp_v) $display("FAIL resume_increment: got %h expected %h", {running, overflow, bcd}, exp_v);
        else n_pass++;
    endtask

    task automatic test_clear_priority();
        clear = 1'b1; start_stop = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_total++;
        if ({running, overflow, bcd} !== 18'h0) $display("FAIL clear_wins: got %h expected %h", {running, overflow, bcd}, 18'h0);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++;
            if ({running, bcd} !== 17'h0) $display("FAIL held_no_refire: got %h expected %h", {running, bcd}, 17'h0);
            else n_pass++;
        end
        start_stop = 1'b0;
        @(negedge clk);
        start_stop = 1'b1;
        run_edges = 0;
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            run_edges++;
            exp_q.push_back({2'b10, to_bcd(run_edges / 2)});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_total++;
            if ({running, overflow, bcd} !== exp_v) $display("FAIL held_single_transition: got %h expected %h", {running, overflow, bcd}, exp_v);
            else n_pass++;
        end
        start_stop = 1'b0;
    endtask

    task automatic test_lap();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        run_edges = 0;
        repeat (84) begin
            run_edges++;
            @(negedge clk);
        end
        n_total++;
        if (bcd !== 16'h0042) $display("FAIL lap_setup: got %h expected %h", bcd, 16'h0042);
        else n_pass++;
        lap = 1'b1;
        run_edges++;
        exp_q.push_back({2'b10, 16'h0042});
        @(negedge clk);
        lap = 1'b0;
        exp_v = exp_q.pop_front();
        n_total++;
        if ({running, overflow, bcd} !== exp_v) $display("FAIL lap_capture: got %h expected %h", {running, overflow, bcd}, exp_v);
        else n_pass++;
        for (int c = 0; c < 19; c++) begin
            run_edges++;
`ifdef BCD_LAP_HOLD_EN
            exp_q.push_back({2'b10, 16'h0042});
`else
            exp_q.push_back({2'b10, to_bcd(run_edges / 2)});
`endif
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_total++;
            if ({running, overflow, bcd} !== exp_v) $display("FAIL lap_hold: got %h expected %h", {running, overflow, bcd}, exp_v);
            else n_pass++;
        end
        lap = 1'b1;
        run_edges++;
        exp_q.push_back({2'b10, 16'h0052});
        @(negedge clk);
        lap = 1'b0;
        exp_v = exp_q.pop_front();
        n_total++;
        if ({running, overflow, bcd} !== exp_v) $display("FAIL lap_release: got %h expected %h", {running, overflow, bcd}, exp_v);
        else n_pass++;
        run_edges++;
        exp_q.push_back({2'b10, to_bcd(run_edges / 2)});
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_total++;
        if ({running, overflow, bcd} !== exp_v) $display("FAIL lap_live: got %h expected %h", {running, overflow, bcd}, exp_v);
        else n_pass++;
    endtask

    task automatic test_overflow();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_total++;
        if ({running, overflow, bcd} !== 18'h0) $display("FAIL ovf_clear_start: got %h expected %h", {running, overflow, bcd}, 18'h0);
        else n_pass++;
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        run_edges = 0;
        for (int c = 0; c < 20004; c++) begin
            run_edges++;
            exp_q.push_back({1'b1, (run_edges >= 20000), to_bcd(run_edges / 2)});
            @(negedge clk);
            exp_v = exp_q.pop_front();
            n_total++;
            if ({running, overflow, bcd} !== exp_v) $display("FAIL ovf_count: got %h expected %h", {running, overflow, bcd}, exp_v);
            else n_pass++;
            if (run_edges == 19998) begin
                n_total++;
                if ({overflow, bcd} !== {1'b0, 16'h9999}) $display("FAIL all_nines: got %h expected %h", {overflow, bcd}, {1'b0, 16'h9999});
                else n_pass++;
            end
            if (run_edges == 20000) begin
                n_total++;
                if ({overflow, bcd} !== {1'b1, 16'h0000}) $display("FAIL wrap_overflow: got %h expected %h", {overflow, bcd}, {1'b1, 16'h0000});
                else n_pass++;
            end
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_total++;
        if ({running, overflow, bcd} !== 18'h0) $display("FAIL ovf_cleared: got %h expected %h", {running, overflow, bcd}, 18'h0);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
        repeat (246) @(negedge clk);
        n_total++;
        if (bcd !== 16'h0123) $display("FAIL midrun_setup: got %h expected %h", bcd, 16'h0123);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({running, overflow, bcd} !== 18'h0) $display("FAIL async_reset: got %h expected %h", {running, overflow, bcd}, 18'h0);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_total++;
        if ({running, overflow, bcd} !== 18'h0) $display("FAIL post_reset_idle: got %h expected %h", {running, overflow, bcd}, 18'h0);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        test_reset();
        test_count();
        test_pause();
        test_clear_priority();
        test_lap();
        test_overflow();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
